imager_readout_sequencer: RTL and testbench
===========================================

IMAGER_READOUT_SEQUENCER -- requirements
Module: imager_readout_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 4: pixel-reset pulse length in okClk cycles (>=1).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 3: row/column select settle time before conversion (>=1).
REQ-003 SHALL have parameter PIX_W, default 16: ADC sample width.
REQ-004 okClk  in  1  sole clock; all logic rising-edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle trigger from host trigger-in endpoint; begins a frame.
REQ-007 abort  in  1  one-cycle trigger; terminates the frame in progress.
REQ-008 cfg_rows, cfg_cols  in  8 each  frame size; value 0 means 256.
REQ-009 cfg_expose  in  16  exposure length in cycles; 0 means no exposure delay.
REQ-010 row_sel, col_sel  out  8 each  current pixel address.
REQ-011 px_rst  out  1  pixel reset drive.
REQ-012 adc_start  out  1  one-cycle convert request.
REQ-013 adc_done / adc_data  in  1 / PIX_W  conversion complete strobe / sample, valid with adc_done.
REQ-014 fifo_full  in  1; fifo_wr_en  out  1; fifo_din  out  PIX_W  pipe-out FIFO write port.
REQ-015 busy  out  1; frame_done  out  1 (pulse); frame_cnt  out  16; ovf  out  1 (sticky).

Function
REQ-016 States: IDLE, PRST, EXPOSE, SETTLE, CONV, WRITE, DONE.
REQ-017 IDLE: start -> PRST; cfg_* latched on that edge and held for the whole frame.
REQ-018 PRST: px_rst=1 for exactly RST_CYCLES cycles, then EXPOSE.
REQ-019 EXPOSE: remain cfg_expose cycles (0 -> skip directly to SETTLE); row_sel=col_sel=0 on entry.
REQ-020 SETTLE: hold address SETTLE_CYCLES cycles, then CONV with adc_start=1 on the first CONV cycle only.
REQ-021 CONV: wait for adc_done; capture adc_data into fifo_din; go to WRITE. An adc_done in the same cycle as adc_start SHALL be accepted.
REQ-022 WRITE: fifo_wr_en=1 for exactly one cycle when fifo_full=0; while fifo_full=1 hold (stall, no write, data kept).
REQ-023 After write: col+1; at col=cfg_cols-1 wrap col to 0 and row+1; at last pixel (row=cfg_rows-1, col=cfg_cols-1) go to DONE, else SETTLE.
REQ-024 Counter arithmetic 8-bit; cfg 0 decodes as 256 so wrap occurs at col=255.
REQ-025 DONE: frame_done=1 for one cycle, frame_cnt+1 (16-bit wrap 0xFFFF->0), return to IDLE.
REQ-026 busy=1 in every state except IDLE.
REQ-027 start while busy SHALL be ignored and SHALL set ovf; ovf cleared only by rst.
REQ-028 abort in any non-IDLE state: next state IDLE, no further fifo_wr_en, px_rst/adc_start deasserted, no frame_done, frame_cnt unchanged; abort and start same cycle in IDLE: abort wins, stay IDLE.
REQ-029 adc_done outside CONV SHALL be ignored.
REQ-030 Throughput: per pixel SETTLE_CYCLES + ADC latency + 1 write cycle + stall cycles.

Reset
REQ-031 rst asserted: state IDLE immediately; all outputs 0 (row_sel, col_sel, px_rst, adc_start, fifo_wr_en, fifo_din, busy, frame_done, frame_cnt, ovf).
REQ-032 rst mid-frame discards the frame; no write or frame_done after release.
REQ-033 First start accepted on first clock edge after rst deasserts.

Verification
REQ-034 cfg_rows=2, cfg_cols=3, cfg_expose=10, ADC done 2 cycles after start, fifo_full=0 -> 6 writes, addresses (0,0)..(1,2) in raster order, data matches, one frame_done, frame_cnt=1.
REQ-035 fifo_full held 5 cycles during WRITE -> no wr_en during stall, exactly one write after release, data unchanged.
REQ-036 abort during third pixel CONV -> IDLE next cycle, 2 writes total, frame_done never, frame_cnt=0.
REQ-037 start pulsed during EXPOSE -> ignored, ovf=1, frame completes normally.
REQ-038 rst asserted in SETTLE asynchronously (between edges) -> all outputs 0 before next edge; start after release runs a full frame from (0,0).
REQ-039 cfg_cols=0, cfg_rows=1, cfg_expose=0 -> 256 writes, col wraps 255->done, EXPOSE skipped (PRST directly to SETTLE).

Source files
------------

// File: rtl/imager_readout_sequencer.sv
// Frame readout sequencer for a pixel-array imager: pixel reset, exposure,
// then a raster walk issuing one ADC conversion per pixel into the pipe-out FIFO.
module imager_readout_sequencer #(
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 3,
  parameter int PIX_W         = 16
) (
  input  logic             okClk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       cfg_rows,
  input  logic [7:0]       cfg_cols,
  input  logic [15:0]      cfg_expose,
  output logic [7:0]       row_sel,
  output logic [7:0]       col_sel,
  output logic             px_rst,
  output logic             adc_start,
  input  logic             adc_done,
  input  logic [PIX_W-1:0] adc_data,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [PIX_W-1:0] fifo_din,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_cnt,
  output logic             ovf
);

  typedef enum logic [2:0] {IDLE, PRST, EXPOSE, SETTLE, CONV, WRITE, DONE} state_t;

  state_t      state, nextState;
  logic [15:0] cnt;
  logic [7:0]  rowsLat, colsLat;
  logic [15:0] exposeLat;
  logic        convIssued;
  logic        lastCol, lastRow;

  // cfg value 0 means 256; 8-bit subtraction maps it to 255 naturally
  assign lastCol = (col_sel == colsLat - 8'd1);
  assign lastRow = (row_sel == rowsLat - 8'd1);

  always_ff @(posedge okClk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState  = state;
    px_rst     = 1'b0;
    adc_start  = 1'b0;
    fifo_wr_en = 1'b0;
    frame_done = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:   if (start && !abort) nextState = PRST;
      PRST: begin
        px_rst = 1'b1;
        if (cnt == 16'(RST_CYCLES - 1))
          nextState = (exposeLat == 16'd0) ? SETTLE : EXPOSE;
      end
      EXPOSE: if (cnt == exposeLat - 16'd1) nextState = SETTLE;
      SETTLE: if (cnt == 16'(SETTLE_CYCLES - 1)) nextState = CONV;
      CONV: begin
        adc_start = !convIssued;
        if (adc_done) nextState = WRITE;
      end
      WRITE: if (!fifo_full) begin
        fifo_wr_en = 1'b1;
        nextState  = (lastRow && lastCol) ? DONE : SETTLE;
      end
      DONE: begin
        frame_done = 1'b1;
        nextState  = IDLE;
      end
      default: nextState = IDLE;
    endcase
    // abort kills the frame this very cycle, including any strobe it would emit
    if (abort && state != IDLE) begin
      nextState  = IDLE;
      px_rst     = 1'b0;
      adc_start  = 1'b0;
      fifo_wr_en = 1'b0;
      frame_done = 1'b0;
    end
  end

  always_ff @(posedge okClk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      rowsLat    <= '0;
      colsLat    <= '0;
      exposeLat  <= '0;
      convIssued <= 1'b0;
      row_sel    <= '0;
      col_sel    <= '0;
      fifo_din   <= '0;
      frame_cnt  <= '0;
      ovf        <= 1'b0;
    end else begin
      cnt        <= (nextState != state) ? 16'd0 : cnt + 16'd1;
      convIssued <= (state == CONV) && (nextState == CONV);
      if (start && state != IDLE) ovf <= 1'b1;
      if (state == IDLE && nextState == PRST) begin
        rowsLat   <= cfg_rows;
        colsLat   <= cfg_cols;
        exposeLat <= cfg_expose;
        row_sel   <= '0;
        col_sel   <= '0;
      end
      if (state == CONV && adc_done) fifo_din <= adc_data;
      if (fifo_wr_en) begin
        if (lastCol) begin
          col_sel <= '0;
          row_sel <= lastRow ? 8'd0 : row_sel + 8'd1;
        end else begin
          col_sel <= col_sel + 8'd1;
        end
      end
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_imager_readout_sequencer.sv
// Directed bench for imager_readout_sequencer: a latency-programmable ADC model
// and a write logger run on the falling edge; stimulus is driven 1ns after rising edges.
`timescale 1ns/1ps
module tb_imager_readout_sequencer;

  logic        okClk, rst, start, abort;
  logic [7:0]  cfg_rows, cfg_cols;
  logic [15:0] cfg_expose;
  logic [7:0]  row_sel, col_sel;
  logic        px_rst, adc_start, adc_done, fifo_full, fifo_wr_en;
  logic [15:0] adc_data, fifo_din;
  logic        busy, frame_done, ovf;
  logic [15:0] frame_cnt;

  imager_readout_sequencer #(.RST_CYCLES(4), .SETTLE_CYCLES(3), .PIX_W(16)) dut (
    .okClk(okClk), .rst(rst), .start(start), .abort(abort),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_expose(cfg_expose),
    .row_sel(row_sel), .col_sel(col_sel), .px_rst(px_rst), .adc_start(adc_start),
    .adc_done(adc_done), .adc_data(adc_data), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .ovf(ovf)
  );

  initial okClk = 1'b0;
  always #5 okClk = ~okClk;

  int total = 0, bad = 0;
  int adcLat = 2, junkCyc = -1;
  int cyc = 0, seq = 0, pend = 0;
  int wrCnt = 0, doneCnt = 0, pxCnt = 0, busyCnt = 0, stCnt = 0;
  logic [7:0]  logRow [1024];
  logic [7:0]  logCol [1024];
  logic [15:0] logDat [1024];
  int bW, bD, bP, bB, bS, bA;

  // ADC model + monitor
  initial begin
    adc_done = 1'b0;
    adc_data = '0;
    forever begin
      @(negedge okClk);
      cyc++;
      if (fifo_wr_en && wrCnt < 1024) begin
        logRow[wrCnt] = row_sel;
        logCol[wrCnt] = col_sel;
        logDat[wrCnt] = fifo_din;
        wrCnt++;
      end
      if (frame_done) doneCnt++;
      if (px_rst)     pxCnt++;
      if (busy)       busyCnt++;
      if (adc_start)  stCnt++;
      adc_done = 1'b0;
      if (rst) pend = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          adc_done = 1'b1;
          adc_data = 16'(16'h3000 + seq);
          seq++;
        end
      end
      if (cyc == junkCyc) begin
        adc_done = 1'b1;
        adc_data = 16'hDEAD;
      end
      if (adc_start) begin
        if (adcLat == 0) begin
          adc_done = 1'b1;
          adc_data = 16'(16'h3000 + seq);
          seq++;
        end else begin
          pend = adcLat;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge okClk);
    #1;
  endtask

  task automatic snap();
    bW = wrCnt; bD = doneCnt; bP = pxCnt; bB = busyCnt; bS = seq; bA = stCnt;
  endtask

  // start accepted on the next edge; cfg is then scrambled to prove it was latched
  task automatic startFrame(input logic [7:0] r, input logic [7:0] c, input logic [15:0] e, input int lat);
    cfg_rows = r; cfg_cols = c; cfg_expose = e; adcLat = lat;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    cfg_rows = 8'd5; cfg_cols = 8'd9; cfg_expose = 16'd50;
  endtask

  task automatic waitIdle(input int maxCyc);
    int n;
    n = 0;
    while (busy && n < maxCyc) begin
      tick(1);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic checkLog(input string tag, input int n, input int cols);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_row"}, 32'(logRow[bW+i]), 32'(i / cols));
      chk({tag, "_col"}, 32'(logCol[bW+i]), 32'(i % cols));
      chk({tag, "_dat"}, 32'(logDat[bW+i]), 32'(16'(16'h3000 + bS + i)));
    end
  endtask

  task automatic chkZero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_row"},  32'(row_sel), 0);
    chk({tag, "_col"},  32'(col_sel), 0);
    chk({tag, "_strb"}, 32'({px_rst, adc_start, fifo_wr_en, frame_done}), 0);
    chk({tag, "_din"},  32'(fifo_din), 0);
    chk({tag, "_fcnt"}, 32'(frame_cnt), 0);
    chk({tag, "_ovf"},  32'(ovf), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; fifo_full = 1'b0;
    cfg_rows = '0; cfg_cols = '0; cfg_expose = '0;
    tick(3);
    chkZero("reset");

    // 2x3 frame, exposure 10, ADC latency 2; junk adc_done injected in SETTLE
    rst = 1'b0;
    snap();
    startFrame(8'd2, 8'd3, 16'd10, 2);
    chk("first_start", 32'(busy), 1);
    tick(14);
    junkCyc = cyc + 1;
    waitIdle(200);
    chk("t1_writes", wrCnt - bW, 6);
    checkLog("t1", 6, 3);
    chk("t1_done", doneCnt - bD, 1);
    chk("t1_fcnt", 32'(frame_cnt), 1);
    chk("t1_pxrst", pxCnt - bP, 4);
    chk("t1_busy", busyCnt - bB, 57);
    chk("t1_adcst", stCnt - bA, 6);
    chk("t1_ovf", 32'(ovf), 0);

    // FIFO stall: five full WRITE cycles on the first pixel
    snap();
    fifo_full = 1'b1;
    startFrame(8'd1, 8'd2, 16'd0, 1);
    tick(14);
    chk("t2_stall_wr", wrCnt - bW, 0);
    chk("t2_stall_en", 32'(fifo_wr_en), 0);
    chk("t2_stall_din", 32'(fifo_din), 32'(16'(16'h3000 + bS)));
    fifo_full = 1'b0;
    waitIdle(200);
    chk("t2_writes", wrCnt - bW, 2);
    checkLog("t2", 2, 2);
    chk("t2_busy", busyCnt - bB, 22);
    chk("t2_fcnt", 32'(frame_cnt), 2);

    // abort on the first CONV cycle of the third pixel
    snap();
    startFrame(8'd2, 8'd3, 16'd0, 2);
    tick(21);
    chk("t3_in_conv", 32'(adc_start), 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t3_idle", 32'(busy), 0);
    tick(10);
    chk("t3_writes", wrCnt - bW, 2);
    checkLog("t3", 2, 3);
    chk("t3_done", doneCnt - bD, 0);
    chk("t3_fcnt", 32'(frame_cnt), 2);
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    chk("t3_abort_wins", 32'(busy), 0);
    chk("t3_ovf", 32'(ovf), 0);

    // start during EXPOSE is ignored and sets ovf
    snap();
    startFrame(8'd1, 8'd2, 16'd10, 2);
    tick(5);
    chk("t4_ovf_pre", 32'(ovf), 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("t4_ovf_set", 32'(ovf), 1);
    waitIdle(200);
    chk("t4_writes", wrCnt - bW, 2);
    checkLog("t4", 2, 2);
    chk("t4_done", doneCnt - bD, 1);
    chk("t4_fcnt", 32'(frame_cnt), 3);
    chk("t4_busy", busyCnt - bB, 29);
    chk("t4_ovf_hold", 32'(ovf), 1);

    // async reset between edges while in SETTLE of the second pixel
    snap();
    startFrame(8'd2, 8'd2, 16'd3, 2);
    tick(14);
    chk("t5_pre_col", 32'(col_sel), 1);
    #3 rst = 1'b1;
    #1 chkZero("t5_rst");
    #2 rst = 1'b0;
    tick(5);
    chk("t5_post_wr", wrCnt - bW, 1);
    chk("t5_post_done", doneCnt - bD, 0);
    snap();
    startFrame(8'd2, 8'd2, 16'd3, 2);
    waitIdle(200);
    chk("t5_writes", wrCnt - bW, 4);
    checkLog("t5", 4, 2);
    chk("t5_busy", busyCnt - bB, 36);
    chk("t5_fcnt", 32'(frame_cnt), 1);

    // cols=0 -> 256, no exposure, ADC answers in the adc_start cycle
    snap();
    startFrame(8'd1, 8'd0, 16'd0, 0);
    waitIdle(2000);
    chk("t6_writes", wrCnt - bW, 256);
    checkLog("t6", 256, 256);
    chk("t6_busy", busyCnt - bB, 1285);
    chk("t6_done", doneCnt - bD, 1);
    chk("t6_fcnt", 32'(frame_cnt), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
